// File: rtl/axi4_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_pkg
// Definitions shared by the AXI4-Lite command master and the AXI4-Lite slave.
//   - AXI response codes (RRESP / BRESP encodings)
//   - axi_mst_state_t: state encoding of the command master FSM
// ---------------------------------------------------------------------------
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // waiting for a command
        ST_WR      = 3'd1,  // AW and W channels in flight
        ST_WR_RESP = 3'd2,  // waiting for BVALID
        ST_RD_ADDR = 3'd3,  // AR channel in flight
        ST_RD_DATA = 3'd4,  // waiting for RVALID
        ST_RSP     = 3'd5   // presenting the response to the host
    } axi_mst_state_t;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_cmd_master
// Turns single-beat read/write commands into AXI4-Lite transactions, one at a
// time, and returns read data / response on a valid-ready response port.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   in_cmd_*/out_cmd_ready command port (write flag, byte address, write data)
//   out_rsp_*/in_rsp_ready response port (write echo, read data, AXI resp)
//   out_err / in_err_clr   sticky non-OKAY flag and its clear
//   out_wr_count/rd_count  completed transaction counters (wrap at 16 bits)
//   out_m_* / in_m_*       AXI4-Lite master side: AR, R, AW, W, B channels
// ---------------------------------------------------------------------------
module axi4_lite_cmd_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // command port
    input  logic                  in_cmd_valid,
    output logic                  out_cmd_ready,
    input  logic                  in_cmd_write,
    input  logic [ADDR_WIDTH-1:0] in_cmd_addr,
    input  logic [DATA_WIDTH-1:0] in_cmd_wdata,
    // response port
    output logic                  out_rsp_valid,
    input  logic                  in_rsp_ready,
    output logic                  out_rsp_write,
    output logic [DATA_WIDTH-1:0] out_rsp_rdata,
    output logic [1:0]            out_rsp_resp,
    // status
    output logic                  out_err,
    input  logic                  in_err_clr,
    output logic [15:0]           out_wr_count,
    output logic [15:0]           out_rd_count,
    // AXI read address
    output logic [ADDR_WIDTH-1:0] out_m_araddr,
    output logic                  out_m_arvalid,
    input  logic                  in_m_arready,
    // AXI read data
    input  logic [DATA_WIDTH-1:0] in_m_rdata,
    input  logic [1:0]            in_m_rresp,
    input  logic                  in_m_rvalid,
    output logic                  out_m_rready,
    // AXI write address
    output logic [ADDR_WIDTH-1:0] out_m_awaddr,
    output logic                  out_m_awvalid,
    input  logic                  in_m_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0] out_m_wdata,
    output logic                  out_m_wvalid,
    input  logic                  in_m_wready,
    // AXI write response
    input  logic [1:0]            in_m_bresp,
    input  logic                  in_m_bvalid,
    output logic                  out_m_bready
);

    axi_mst_state_t        state_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  awvalid_q, wvalid_q, arvalid_q, rready_q, bready_q;
    logic                  aw_done_q, w_done_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  err_q;
    logic [15:0]           wr_count_q, rd_count_q;

    // Handshake tracking for the two independent write channels. The _d
    // values include a handshake happening this cycle, so the FSM leaves WR
    // on the same edge as the last of the two handshakes.
    logic aw_done_d, w_done_d;
    assign aw_done_d = aw_done_q | (awvalid_q & in_m_awready);
    assign w_done_d  = w_done_q  | (wvalid_q  & in_m_wready);

    // A response is captured on a B or R handshake; drives the sticky error.
    logic       cap_en;
    logic [1:0] cap_resp;
    assign cap_en   = (bready_q & in_m_bvalid) | (rready_q & in_m_rvalid);
    assign cap_resp = rready_q ? in_m_rresp : in_m_bresp;

    // The only unregistered output: ready is a state decode, gated by reset
    // so the host never sees ready while the master is being reset.
    assign out_cmd_ready = aresetn & (state_q == ST_IDLE);

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!aresetn) begin
            // NOTE: reset clears the command/data registers too, not just the
            // control bits, so the AXI address/data buses read 0 in reset.
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            err_q       <= 1'b0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            // A capture of a non-OKAY response beats a simultaneous clear.
            if (cap_en && cap_resp != RESP_OKAY) begin
                err_q <= 1'b1;
            end else if (in_err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_cmd_valid) begin
                        write_q <= in_cmd_write;
                        addr_q  <= in_cmd_addr;
                        wdata_q <= in_cmd_wdata;
                        if (in_cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (in_m_awready) awvalid_q <= 1'b0;
                    if (in_m_wready)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (in_m_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= in_m_bresp;
                        wr_count_q  <= wr_count_q + 16'd1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (in_m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (in_m_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= in_m_rdata;
                        rsp_resp_q  <= in_m_rresp;
                        rd_count_q  <= rd_count_q + 16'd1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (in_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_m_awaddr  = addr_q;
    assign out_m_araddr  = addr_q;
    assign out_m_wdata   = wdata_q;
    assign out_m_awvalid = awvalid_q;
    assign out_m_wvalid  = wvalid_q;
    assign out_m_arvalid = arvalid_q;
    assign out_m_rready  = rready_q;
    assign out_m_bready  = bready_q;
    assign out_rsp_valid = rsp_valid_q;
    assign out_rsp_write = write_q;
    assign out_rsp_rdata = rsp_rdata_q;
    assign out_rsp_resp  = rsp_resp_q;
    assign out_err       = err_q;
    assign out_wr_count  = wr_count_q;
    assign out_rd_count  = rd_count_q;

endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

Command-driven AXI4-Lite master that sits directly upstream of `axi4_lite_slave`, converting single-beat read/write commands from a simple valid/ready command port into AXI4-Lite transactions on the five channels. It issues one transaction at a time and returns the read data and response on a valid/ready response port. It is the host-side driver for the BRAM and configuration-register slave, for both system integration and the slave's own test bench.

## Interface

Parameters:
- `ADDR_WIDTH`, 12, address width; matches the slave.
- `DATA_WIDTH`, 32, data width; multiple of 8.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: synchronous, active-low reset.
- `in_cmd_valid` in 1: command valid.
- `out_cmd_ready` out 1: master can accept a command.
- `in_cmd_write` in 1: 1 = write, 0 = read.
- `in_cmd_addr` in ADDR_WIDTH: target byte address.
- `in_cmd_wdata` in DATA_WIDTH: write data; ignored on reads.
- `out_rsp_valid` out 1: response valid.
- `in_rsp_ready` in 1: consumer accepts the response.
- `out_rsp_write` out 1: echoes `in_cmd_write` of the completed command.
- `out_rsp_rdata` out DATA_WIDTH: read data; 0 for writes.
- `out_rsp_resp` out 2: RRESP or BRESP as received.
- `out_err` out 1: sticky; set by any response that is not OKAY.
- `in_err_clr` in 1: clears `out_err`. If a non-OKAY capture occurs in the same cycle, the capture wins.
- `out_wr_count`, `out_rd_count` out 16 each: completed write/read transactions; wrap 0xFFFF→0.
- AXI ports, master side of the slave's channels:
  - Read address: `out_m_araddr`, `out_m_arvalid`, `in_m_arready`.
  - Read data: `in_m_rdata`, `in_m_rresp`, `in_m_rvalid`, `out_m_rready`.
  - Write address: `out_m_awaddr`, `out_m_awvalid`, `in_m_awready`.
  - Write data: `out_m_wdata`, `out_m_wvalid`, `in_m_wready`.
  - Write response: `in_m_bresp`, `in_m_bvalid`, `out_m_bready`.

## Operation

State machine states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.

- **IDLE**
  - `out_cmd_ready`=1.
  - On `in_cmd_valid`, latch write, addr and wdata.
  - Go to WR (write) or RD_ADDR (read).
- **WR**
  - `out_m_awvalid` and `out_m_wvalid` assert together on entry.
  - Each valid drops independently in the cycle after its own handshake (`valid&ready`), tracked by flags `aw_done`/`w_done`.
  - The AW and W handshakes may occur in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- **WR_RESP**
  - `out_m_bready`=1.
  - On `in_m_bvalid`, capture bresp, set rdata=0, increment `out_wr_count`, go to RSP.
- **RD_ADDR**
  - `out_m_arvalid`=1 until `in_m_arready`, then go to RD_DATA.
- **RD_DATA**
  - `out_m_rready`=1.
  - On `in_m_rvalid`, capture rdata and rresp, increment `out_rd_count`, go to RSP.
- **RSP**
  - `out_rsp_valid`=1 and held stable until `in_rsp_ready`, then go to IDLE.

Protocol rules:
- Once asserted, no valid is deasserted before its handshake.
- Address and data stay stable while valid is asserted.
- The master never aborts a transaction.
- `out_m_awaddr`, `out_m_araddr` and `out_m_wdata` are driven from the latched command register.
- `out_err` is set in the capture cycle when resp != 2'b00.

Reset (while `aresetn`=0 at a rising edge):
- State goes to IDLE.
- All valid/ready outputs go to 0, including `out_cmd_ready`, which is forced 0 during reset.
- Addresses, data, rdata, resp, counters and `out_err` go to 0.
- Reset mid-transaction abandons the transaction; the slave is reset on the same `aresetn`.

## Timing

- All outputs are registered except `out_cmd_ready`, which is decoded from the state.
- Best case, command accepted at cycle 0:
  - AXI valids are high at cycle 1.
  - If the slave's ready is high at cycle 1, `bready`/`rready` is high at cycle 2.
  - If `bvalid`/`rvalid` is high at cycle 2, `out_rsp_valid` is high at cycle 3.
- Minimum command-to-response latency is 3 cycles.
- Back-to-back: with `in_rsp_ready`=1, the next command is accepted at cycle 4. Throughput is at most 1 transaction per 4 cycles.
- Slave stalls on any channel extend the current state indefinitely. There is no timeout.
- Response backpressure holds RSP. The counters have already incremented.

## Structure

- Shared package `axi4_lite_pkg` holds:
  - Response constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The `axi_mst_state_t` enum.
- The slave also imports the response constants from this package.
- Single module; no sub-module is warranted.

## Test plan

- **Write, zero-wait slave:** write addr=0x010, wdata=0xDEADBEEF, awready=wready=1, bvalid at the first bready, bresp=0.
  - AW/W handshake at cycle 1.
  - `out_rsp_valid` at cycle 3 with resp=0.
  - `out_wr_count`=1.
- **Read:** read addr=0x014, arready delayed 2 cycles, rvalid with rdata=0x12345678 and rresp=0.
  - `out_m_arvalid` held 3 cycles.
  - `out_rsp_rdata`=0x12345678.
  - `out_rd_count`=1.
- **Skewed write channels:** wready high at cycle 1, awready high at cycle 4.
  - wvalid drops at cycle 2.
  - awvalid stays high through cycle 4.
  - bready first asserted at cycle 5.
- **Error path:** read returns rresp=2'b10.
  - `out_rsp_resp`=2'b10 and `out_err`=1.
  - `out_err` stays 1 after the next OKAY transaction.
  - Clears one cycle after `in_err_clr`.
- **Response backpressure:** `in_rsp_ready`=0 for 5 cycles.
  - `out_rsp_valid` and data are stable.
  - `out_cmd_ready`=0.
  - A new command is accepted the cycle after the response handshake.
- **Reset mid-write:** `aresetn`=0 while in WR with awvalid=1.
  - All outputs are 0 after the next edge.
  - After release, the state is IDLE and `out_cmd_ready`=1.
